// File: rtl/prog_imem.sv
// prog_imem: run-time loadable instruction memory.
//
// A program is streamed in through the load port. The core then fetches
// words with a registered one-cycle latency. Any fetch at or beyond the
// loaded program length returns OOR_WORD and raises instr_oor.
//
// Ports:
//   clk, rst_n       clock; synchronous active-low reset
//   load_start       pulse: begin a new program load at address 0
//   load_valid       load word present on load_data
//   load_data        instruction word to store
//   load_last        marks load_data as the final program word
//   load_ready       a load word is accepted this cycle
//   busy             high while a load is in progress
//   prog_len         number of valid words in the loaded program
//   fetch_req        fetch request
//   fetch_addr       fetch address
//   fetch_ready      fetch accepted this cycle (IDLE/RUN only)
//   instr            fetched instruction (registered)
//   instr_valid      instr was updated by the fetch accepted last cycle
//   instr_oor        instr is OOR_WORD because the address was out of range
//   state_dbg        current FSM state (0 IDLE, 1 LOAD, 2 RUN)
//
// Handshakes: a word moves on a rising edge when valid and ready are both
// high in the cycle before it (load_valid & load_ready, fetch_req &
// fetch_ready). Ready never depends on valid; both depend on state only.
module prog_imem #(
  parameter int                 DATA_W   = 8,
  parameter int                 ADDR_W   = 8,
  parameter int                 DEPTH    = 256,
  parameter logic [DATA_W-1:0]  OOR_WORD = 8'hC0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              busy,
  output logic [ADDR_W:0]   prog_len,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic              instr_oor,
  output logic [1:0]        state_dbg
);

  // DEPTH <= 2**ADDR_W, so PTR_W never exceeds ADDR_W.
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [PTR_W-1:0]  ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              load_hs;
  logic              final_word;
  logic              start_load;
  logic              fetch_acc;
  logic              in_range;
  logic [PTR_W-1:0]  fetch_idx;

  assign load_ready  = (state == S_LOAD);
  assign busy        = (state == S_LOAD);
  assign fetch_ready = (state != S_LOAD);
  assign state_dbg   = state;

  assign load_hs    = load_valid & load_ready;
  // The last storage slot ends the load even without load_last, so a
  // runaway stream can never wrap and overwrite address 0.
  assign final_word = load_hs & (load_last | (ptr == PTR_MAX));
  assign start_load = load_start & (state != S_LOAD);
  assign fetch_acc  = fetch_req & fetch_ready;
  // prog_len is ADDR_W+1 bits so that a full memory (DEPTH) is representable.
  assign in_range   = ({1'b0, fetch_addr} < prog_len);
  assign fetch_idx  = fetch_addr[PTR_W-1:0];

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (load_start) state_nxt = S_LOAD;
      S_LOAD:  if (final_word) state_nxt = S_RUN;
      S_RUN:   if (load_start) state_nxt = S_LOAD;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      ptr         <= '0;
      prog_len    <= '0;
      instr       <= OOR_WORD;
      instr_valid <= 1'b0;
      instr_oor   <= 1'b0;
    end else begin
      state <= state_nxt;

      if (start_load) begin
        ptr      <= '0;
        prog_len <= '0;
      end else if (load_hs) begin
        if (final_word) begin
          prog_len <= (ADDR_W+1)'(ptr) + (ADDR_W+1)'(1);
        end else begin
          ptr <= ptr + PTR_W'(1);
        end
      end

      // A fetch in the same cycle as load_start still sees the old
      // prog_len and contents; the clear lands on this same edge.
      instr_valid <= fetch_acc;
      if (fetch_acc) begin
        if (in_range) begin
          instr     <= mem[fetch_idx];
          instr_oor <= 1'b0;
        end else begin
          instr     <= OOR_WORD;
          instr_oor <= 1'b1;
        end
      end
    end
  end

  // Storage is not cleared by reset; prog_len = 0 makes it unreachable.
  always_ff @(posedge clk) begin
    if (rst_n && load_hs) begin
      mem[ptr] <= load_data;
    end
  end

endmodule

// File: tb/tb_prog_imem.sv
module tb_prog_imem;

  // Instance 0 uses the default DEPTH; instance 1 uses DEPTH=4 for overflow.
  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_start;
  logic        load_valid;
  logic [7:0]  load_data;
  logic        load_last;
  logic        fetch_req;
  logic [7:0]  fetch_addr;

  logic [1:0]  load_ready_v;
  logic [1:0]  busy_v;
  logic [1:0]  fetch_ready_v;
  logic [1:0]  instr_valid_v;
  logic [1:0]  instr_oor_v;
  logic [8:0]  prog_len_v [2];
  logic [7:0]  instr_v [2];
  logic [1:0]  state_dbg_v [2];

  int          n_checks = 0;
  int          n_errors = 0;

  // Reference model: mode 0 idle, 1 loading, 2 running.
  int          depth_of [2] = '{256, 4};
  int          m_mode [2];
  int          m_cnt  [2];
  int          m_len  [2];
  logic [7:0]  m_mem  [2][256];

  logic [8:0]  exp_q0 [$];
  logic [8:0]  exp_q1 [$];

  prog_imem #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .OOR_WORD(8'hC0)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
    .load_last(load_last), .load_ready(load_ready_v[0]), .busy(busy_v[0]),
    .prog_len(prog_len_v[0]), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_ready(fetch_ready_v[0]), .instr(instr_v[0]),
    .instr_valid(instr_valid_v[0]), .instr_oor(instr_oor_v[0]),
    .state_dbg(state_dbg_v[0])
  );

  prog_imem #(.DATA_W(8), .ADDR_W(8), .DEPTH(4), .OOR_WORD(8'hC0)) u_small (
    .clk(clk), .rst_n(rst_n),
    .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
    .load_last(load_last), .load_ready(load_ready_v[1]), .busy(busy_v[1]),
    .prog_len(prog_len_v[1]), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_ready(fetch_ready_v[1]), .instr(instr_v[1]),
    .instr_valid(instr_valid_v[1]), .instr_oor(instr_oor_v[1]),
    .state_dbg(state_dbg_v[1])
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s[%0d] @%0t: got %0h, expected %0h", name, k, $time, act, exp);
    end
  endtask

  // Model update for one rising edge, using the inputs held across it.
  task automatic model_edge();
    logic [8:0] e;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_mode[k] = 0;
        m_len[k]  = 0;
        m_cnt[k]  = 0;
      end else begin
        if (fetch_req && m_mode[k] != 1) begin
          if (int'(fetch_addr) < m_len[k]) e = {1'b0, m_mem[k][fetch_addr]};
          else                              e = {1'b1, 8'hC0};
          if (k == 0) exp_q0.push_back(e);
          else        exp_q1.push_back(e);
        end
        if (m_mode[k] == 1) begin
          if (load_valid) begin
            m_mem[k][m_cnt[k]] = load_data;
            m_cnt[k]++;
            if (load_last || m_cnt[k] == depth_of[k]) begin
              m_len[k]  = m_cnt[k];
              m_mode[k] = 2;
            end
          end
        end else if (load_start) begin
          m_mode[k] = 1;
          m_cnt[k]  = 0;
          m_len[k]  = 0;
        end
      end
    end
  endtask

  task automatic status_checks();
    for (int k = 0; k < 2; k++) begin
      check("load_ready",  k, 32'(load_ready_v[k]),  32'(m_mode[k] == 1));
      check("busy",        k, 32'(busy_v[k]),        32'(m_mode[k] == 1));
      check("fetch_ready", k, 32'(fetch_ready_v[k]), 32'(m_mode[k] != 1));
      check("prog_len",    k, 32'(prog_len_v[k]),    32'(m_len[k]));
      check("state_dbg",   k, 32'(state_dbg_v[k]),   32'(m_mode[k]));
    end
  endtask

  // One clock: inputs already set; model follows the edge, status at negedge.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    status_checks();
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [8:0] e;
    if (instr_valid_v[0] === 1'b1) begin
      if (exp_q0.size() == 0) check("instr_unexpected", 0, 32'd1, 32'd0);
      else begin
        e = exp_q0.pop_front();
        check("instr", 0, 32'({instr_oor_v[0], instr_v[0]}), 32'(e));
      end
    end
    if (instr_valid_v[1] === 1'b1) begin
      if (exp_q1.size() == 0) check("instr_unexpected", 1, 32'd1, 32'd0);
      else begin
        e = exp_q1.pop_front();
        check("instr", 1, 32'({instr_oor_v[1], instr_v[1]}), 32'(e));
      end
    end
  end

  // ---------------- driver tasks ----------------
  logic [7:0] prog5 [16];

  task automatic do_load(input logic [7:0] w [16], input int n, input int bubble,
                         input bit use_last);
    load_start = 1'b1;
    cycle();
    load_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (i == bubble) begin
        load_valid = 1'b0;
        cycle();
      end
      load_valid = 1'b1;
      load_data  = w[i];
      load_last  = use_last && (i == n - 1);
      cycle();
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic fetch_one(input logic [7:0] a);
    fetch_req  = 1'b1;
    fetch_addr = a;
    cycle();
    fetch_req  = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] exp_basic [6];
    logic [7:0] rw [16];
    int n, r;

    prog5 = '{default: 8'h00};
    prog5[0] = 8'h44; prog5[1] = 8'h49; prog5[2] = 8'h18;
    prog5[3] = 8'h89; prog5[4] = 8'hC3;
    exp_basic = '{8'h44, 8'h49, 8'h18, 8'h89, 8'hC3, 8'hC0};

    rst_n = 1'b0; load_start = 1'b0; load_valid = 1'b0; load_data = 8'h00;
    load_last = 1'b0; fetch_req = 1'b0; fetch_addr = 8'h00;

    // Reset state
    cycle();
    cycle();
    for (int k = 0; k < 2; k++) begin
      check("rst_instr",       k, 32'(instr_v[k]),       32'h0C0);
      check("rst_instr_valid", k, 32'(instr_valid_v[k]), 32'd0);
      check("rst_instr_oor",   k, 32'(instr_oor_v[k]),   32'd0);
      check("rst_load_ready",  k, 32'(load_ready_v[k]),  32'd0);
      check("rst_busy",        k, 32'(busy_v[k]),        32'd0);
      check("rst_prog_len",    k, 32'(prog_len_v[k]),    32'd0);
    end
    rst_n = 1'b1;
    fetch_one(8'd0);
    check("post_rst_fetch", 0, 32'({instr_valid_v[0], instr_oor_v[0], instr_v[0]}),
          32'h3C0);

    // Basic load with one bubble, then fetch 0..5 back to back
    do_load(prog5, 5, 2, 1'b1);
    check("basic_prog_len", 0, 32'(prog_len_v[0]), 32'd5);
    check("basic_busy",     0, 32'(busy_v[0]),     32'd0);
    for (int i = 0; i < 6; i++) begin
      fetch_req  = 1'b1;
      fetch_addr = 8'(i);
      cycle();
      check("basic_instr", 0, 32'(instr_v[0]), 32'(exp_basic[i]));
      check("basic_oor",   0, 32'(instr_oor_v[0]), 32'(i == 5));
    end
    fetch_req = 1'b0;

    // Fetch held high through a load
    fetch_req  = 1'b1;
    fetch_addr = 8'd1;
    do_load(prog5, 5, 3, 1'b1);
    cycle();
    check("fetch_after_load", 0, 32'({instr_valid_v[0], instr_v[0]}), 32'h149);
    fetch_req = 1'b0;

    // Overflow on the DEPTH=4 instance: six words, no load_last
    load_start = 1'b1;
    cycle();
    load_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      load_valid = 1'b1;
      load_data  = 8'h10 + 8'(i);
      cycle();
      if (i == 3) begin
        check("ovf_prog_len",   1, 32'(prog_len_v[1]),   32'd4);
        check("ovf_load_ready", 1, 32'(load_ready_v[1]), 32'd0);
      end
    end
    load_valid = 1'b0;
    fetch_one(8'd3);
    check("ovf_addr3", 1, 32'({instr_oor_v[1], instr_v[1]}), 32'h013);
    fetch_one(8'd4);
    check("ovf_addr4", 1, 32'({instr_oor_v[1], instr_v[1]}), 32'h1C0);
    load_valid = 1'b1; load_data = 8'h16; load_last = 1'b1;
    cycle();
    load_valid = 1'b0; load_last = 1'b0;
    check("ovf_big_len", 0, 32'(prog_len_v[0]), 32'd7);

    // Reset in the middle of a load
    do_load(prog5, 2, -1, 1'b0);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    check("midrst_len", 0, 32'(prog_len_v[0]), 32'd0);
    fetch_one(8'd0);
    check("midrst_fetch", 0, 32'({instr_oor_v[0], instr_v[0]}), 32'h1C0);

    // load_start and fetch in the same RUN cycle
    do_load(prog5, 5, -1, 1'b1);
    load_start = 1'b1;
    fetch_req  = 1'b1;
    fetch_addr = 8'd2;
    cycle();
    load_start = 1'b0;
    fetch_req  = 1'b0;
    check("simul_instr", 0, 32'({instr_valid_v[0], instr_v[0]}), 32'h118);
    check("simul_busy",  0, 32'(busy_v[0]),     32'd1);
    check("simul_len",   0, 32'(prog_len_v[0]), 32'd0);
    for (int i = 0; i < 5; i++) begin
      load_valid = 1'b1; load_data = prog5[i]; load_last = (i == 4);
      cycle();
    end
    load_valid = 1'b0; load_last = 1'b0;

    // Randomised traffic
    for (int it = 0; it < 150; it++) begin
      r = $urandom_range(0, 9);
      if (r <= 2) begin
        n = $urandom_range(1, 12);
        for (int i = 0; i < 16; i++) rw[i] = 8'($urandom_range(0, 255));
        fetch_req  = 1'($urandom_range(0, 1));
        fetch_addr = 8'($urandom_range(0, 15));
        load_start = 1'b1;
        cycle();
        load_start = 1'b0;
        for (int i = 0; i < n; i++) begin
          while ($urandom_range(0, 3) == 0) begin
            load_valid = 1'b0;
            cycle();
          end
          load_valid = 1'b1;
          load_data  = rw[i];
          load_last  = (i == n - 1);
          load_start = ($urandom_range(0, 7) == 0);
          cycle();
        end
        load_valid = 1'b0; load_last = 1'b0; load_start = 1'b0; fetch_req = 1'b0;
      end else if (r == 3) begin
        load_start = 1'b1;
        cycle();
        load_start = 1'b0;
        n = $urandom_range(0, 3);
        for (int i = 0; i < n; i++) begin
          load_valid = 1'b1;
          load_data  = 8'($urandom_range(0, 255));
          cycle();
        end
        load_valid = 1'b0;
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
      end else begin
        n = $urandom_range(1, 8);
        for (int i = 0; i < n; i++) begin
          fetch_req  = ($urandom_range(0, 3) != 0);
          fetch_addr = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 7))
                                                   : 8'($urandom_range(0, 255));
          load_valid = ($urandom_range(0, 3) == 0);
          load_data  = 8'($urandom_range(0, 255));
          load_last  = 1'($urandom_range(0, 1));
          cycle();
        end
        fetch_req = 1'b0; load_valid = 1'b0; load_last = 1'b0;
      end
    end

    // Drain and final report
    fetch_req = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    check("queue_left", 0, 32'(exp_q0.size()), 32'd0);
    check("queue_left", 1, 32'(exp_q1.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
